// File: rtl/fetch_ctrl_pkg.sv
// Shared types for the fetch front end: word types, reset PC,
// fetch FSM states and the redirect request bundle.
package fetch_ctrl_pkg;

    typedef logic [63:0] u64;
    typedef logic [31:0] u32;

    localparam u64 PCINIT = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DROP,
        WAIT_DEC
    } fetch_state_t;

    typedef struct packed {
        logic valid;
        u64   pc;
    } fetch_redirect_t;

endpackage

// File: rtl/fetch_redirect_mux.sv
// Priority select between redirect sources (trap > branch).
// Ports: trap, br (redirect bundles) -> redir (any valid), target (winning PC).
module fetch_redirect_mux
    import fetch_ctrl_pkg::*;
(
    input  fetch_redirect_t trap,
    input  fetch_redirect_t br,
    output logic            redir,
    output u64              target
);

    always_comb begin
        redir  = trap.valid | br.valid;
        target = br.pc;
        unique case (1'b1)
            trap.valid: target = trap.pc;
            default:    target = br.pc;
        endcase
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch PC sequencer: drives the instruction-bus request/response
// handshake, applies trap/branch redirects and holds one instruction
// for decode.
// Ports: clk, reset (sync, active-high); ireq_valid/ireq_addr out,
// iresp_ok/iresp_data in; if_valid/if_pc/if_instr out, if_ready in;
// redir_trap_*/redir_br_* in; pc out (current fetch PC).
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter u64 RESET_PC    = PCINIT,
    parameter int INSTR_BYTES = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_ok,
    input  logic [31:0] iresp_data,
    output logic        if_valid,
    output logic [63:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        if_ready,
    input  logic        redir_trap_valid,
    input  logic [63:0] redir_trap_pc,
    input  logic        redir_br_valid,
    input  logic [63:0] redir_br_pc,
    output logic [63:0] pc
);

    localparam u64 STEP = u64'(INSTR_BYTES);

    fetch_state_t state, state_n;
    u64           pc_q, pc_n;
    u64           pend_pc, pend_pc_n;
    u64           buf_pc, buf_pc_n;
    u32           buf_instr, buf_instr_n;

    fetch_redirect_t trap_src, br_src;
    logic            redir;
    u64              target;

    assign trap_src = '{valid: redir_trap_valid, pc: redir_trap_pc};
    assign br_src   = '{valid: redir_br_valid, pc: redir_br_pc};

    fetch_redirect_mux u_redir_mux (
        .trap   (trap_src),
        .br     (br_src),
        .redir  (redir),
        .target (target)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pc_q      <= RESET_PC;
            pend_pc   <= '0;
            buf_pc    <= '0;
            buf_instr <= '0;
        end else begin
            state     <= state_n;
            pc_q      <= pc_n;
            pend_pc   <= pend_pc_n;
            buf_pc    <= buf_pc_n;
            buf_instr <= buf_instr_n;
        end
    end

    always_comb begin
        state_n     = state;
        pc_n        = pc_q;
        pend_pc_n   = pend_pc;
        buf_pc_n    = buf_pc;
        buf_instr_n = buf_instr;
        unique case (state)
            IDLE: begin
                state_n = FETCH;
                if (redir) pc_n = target;
            end
            FETCH: begin
                if (redir && iresp_ok) begin
                    pc_n = target;
                end else if (redir) begin
                    // Request still in flight: keep the address stable
                    // and remember where to go once it returns.
                    pend_pc_n = target;
                    state_n   = DROP;
                end else if (iresp_ok) begin
                    buf_pc_n    = pc_q;
                    buf_instr_n = iresp_data;
                    pc_n        = pc_q + STEP;
                    state_n     = WAIT_DEC;
                end
            end
            DROP: begin
                if (redir) pend_pc_n = target;
                if (iresp_ok) begin
                    pc_n    = redir ? target : pend_pc;
                    state_n = FETCH;
                end
            end
            WAIT_DEC: begin
                if (redir) begin
                    pc_n    = target;
                    state_n = FETCH;
                end else if (if_ready) begin
                    state_n = FETCH;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign ireq_valid = (state == FETCH) || (state == DROP);
    assign ireq_addr  = pc_q;
    assign pc         = pc_q;
    // A redirect kills the buffered instruction in the same cycle.
    assign if_valid   = (state == WAIT_DEC) && !redir;
    assign if_pc      = buf_pc;
    assign if_instr   = buf_instr;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl.
// Hand-computed expectations for reset, fetch, redirect and drop paths.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_ok;
    logic [31:0] iresp_data;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;
    logic        redir_trap_valid;
    logic [63:0] redir_trap_pc;
    logic        redir_br_valid;
    logic [63:0] redir_br_pc;
    logic [63:0] pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .ireq_valid       (ireq_valid),
        .ireq_addr        (ireq_addr),
        .iresp_ok         (iresp_ok),
        .iresp_data       (iresp_data),
        .if_valid         (if_valid),
        .if_pc            (if_pc),
        .if_instr         (if_instr),
        .if_ready         (if_ready),
        .redir_trap_valid (redir_trap_valid),
        .redir_trap_pc    (redir_trap_pc),
        .redir_br_valid   (redir_br_valid),
        .redir_br_pc      (redir_br_pc),
        .pc               (pc)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        iresp_ok         = 1'b0;
        redir_trap_valid = 1'b0;
        redir_br_valid   = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        iresp_ok         = 1'b0;
        iresp_data       = '0;
        if_ready         = 1'b0;
        redir_trap_valid = 1'b0;
        redir_trap_pc    = '0;
        redir_br_valid   = 1'b0;
        redir_br_pc      = '0;
        tick();
        tick();
        chk("rst_ireq_valid", 64'(ireq_valid), 64'd0);
        chk("rst_if_valid", 64'(if_valid), 64'd0);
        chk("rst_addr", ireq_addr, 64'h8000_0000);
        chk("rst_pc", pc, 64'h8000_0000);
        chk("rst_if_pc", if_pc, 64'd0);

        // 1: first fetch, response after 3 request cycles
        reset = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("t1_req_valid", 64'(ireq_valid), 64'd1);
            chk("t1_req_addr", ireq_addr, 64'h8000_0000);
            chk("t1_no_ifv", 64'(if_valid), 64'd0);
            if (i == 2) begin
                iresp_ok   = 1'b1;
                iresp_data = 32'h0000_0013;
            end
            tick();
        end
        clr();
        chk("t1_if_valid", 64'(if_valid), 64'd1);
        chk("t1_if_pc", if_pc, 64'h8000_0000);
        chk("t1_if_instr", 64'(if_instr), 64'h13);
        chk("t1_req_idle", 64'(ireq_valid), 64'd0);
        chk("t1_pc_inc", pc, 64'h8000_0004);

        // 2: decode backpressure
        for (int i = 0; i < 5; i++) begin
            chk("t2_if_valid", 64'(if_valid), 64'd1);
            chk("t2_if_pc", if_pc, 64'h8000_0000);
            chk("t2_if_instr", 64'(if_instr), 64'h13);
            chk("t2_req_off", 64'(ireq_valid), 64'd0);
            tick();
        end
        if_ready = 1'b1;
        tick();
        if_ready = 1'b0;
        chk("t2_req_on", 64'(ireq_valid), 64'd1);
        chk("t2_req_addr", ireq_addr, 64'h8000_0004);
        chk("t2_ifv_off", 64'(if_valid), 64'd0);

        // 3: branch redirect while request outstanding
        redir_br_valid = 1'b1;
        redir_br_pc    = 64'h8000_0100;
        tick();
        clr();
        chk("t3_addr_hold0", ireq_addr, 64'h8000_0004);
        chk("t3_req_valid", 64'(ireq_valid), 64'd1);
        tick();
        chk("t3_addr_hold1", ireq_addr, 64'h8000_0004);
        iresp_ok   = 1'b1;
        iresp_data = 32'hdead_beef;
        tick();
        clr();
        chk("t3_stale_ifv", 64'(if_valid), 64'd0);
        chk("t3_new_addr", ireq_addr, 64'h8000_0100);

        // 4a: trap beats branch in FETCH
        redir_trap_valid = 1'b1;
        redir_trap_pc    = 64'h8000_0200;
        redir_br_valid   = 1'b1;
        redir_br_pc      = 64'h8000_0100;
        tick();
        clr();
        chk("t4a_addr_hold", ireq_addr, 64'h8000_0100);
        iresp_ok = 1'b1;
        tick();
        clr();
        chk("t4a_addr", ireq_addr, 64'h8000_0200);
        chk("t4a_ifv", 64'(if_valid), 64'd0);

        // 4b: trap beats branch in DROP, latest redirect wins
        redir_br_valid = 1'b1;
        redir_br_pc    = 64'h8000_0400;
        tick();
        clr();
        redir_trap_valid = 1'b1;
        redir_trap_pc    = 64'h8000_0200;
        redir_br_valid   = 1'b1;
        redir_br_pc      = 64'h8000_0100;
        tick();
        clr();
        chk("t4b_addr_hold", ireq_addr, 64'h8000_0200);
        iresp_ok = 1'b1;
        tick();
        clr();
        chk("t4b_addr", ireq_addr, 64'h8000_0200);

        // 5a: redirect coincident with response in FETCH
        redir_br_valid = 1'b1;
        redir_br_pc    = 64'h8000_0300;
        iresp_ok       = 1'b1;
        iresp_data     = 32'h1111_1111;
        tick();
        clr();
        chk("t5a_ifv", 64'(if_valid), 64'd0);
        chk("t5a_req_valid", 64'(ireq_valid), 64'd1);
        chk("t5a_addr", ireq_addr, 64'h8000_0300);
        iresp_ok   = 1'b1;
        iresp_data = 32'h0010_0093;
        tick();
        clr();
        chk("t5a_if_pc", if_pc, 64'h8000_0300);
        chk("t5a_if_instr", 64'(if_instr), 64'h0010_0093);

        // 5b: redirect kills buffered instruction even with if_ready
        if_ready       = 1'b1;
        redir_br_valid = 1'b1;
        redir_br_pc    = 64'h8000_0600;
        #1;
        chk("t5b_kill", 64'(if_valid), 64'd0);
        tick();
        clr();
        if_ready = 1'b0;
        chk("t5b_addr", ireq_addr, 64'h8000_0600);
        chk("t5b_ifv", 64'(if_valid), 64'd0);

        // 6: reset while in DROP with late response
        redir_br_valid = 1'b1;
        redir_br_pc    = 64'h8000_0700;
        tick();
        clr();
        reset      = 1'b1;
        iresp_ok   = 1'b1;
        iresp_data = 32'hbad0_bad0;
        tick();
        reset = 1'b0;
        chk("t6_req_off", 64'(ireq_valid), 64'd0);
        chk("t6_ifv", 64'(if_valid), 64'd0);
        chk("t6_pc", pc, 64'h8000_0000);
        tick();
        clr();
        chk("t6_idle_ok_ifv", 64'(if_valid), 64'd0);
        chk("t6_restart", ireq_addr, 64'h8000_0000);
        chk("t6_req_on", 64'(ireq_valid), 64'd1);
        iresp_ok   = 1'b1;
        iresp_data = 32'h0000_0013;
        tick();
        clr();
        chk("t6_if_pc", if_pc, 64'h8000_0000);
        chk("t6_if_instr", 64'(if_instr), 64'h13);

        // 7: 64-bit PC wrap on sequential increment
        redir_trap_valid = 1'b1;
        redir_trap_pc    = 64'hffff_ffff_ffff_fffc;
        tick();
        clr();
        chk("t7_addr", ireq_addr, 64'hffff_ffff_ffff_fffc);
        iresp_ok   = 1'b1;
        iresp_data = 32'h0000_006f;
        tick();
        clr();
        chk("t7_if_pc", if_pc, 64'hffff_ffff_ffff_fffc);
        chk("t7_wrap", pc, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
